uart_rx_ctrl: RTL and testbench

- Sequencing controller for the UART receiver.
- Detects the receiver's completion flag, captures its parallel byte into a small first-word-fall-through FIFO, then pulses the receiver's flag-clear input for exactly one cycle.
- Presents a pop/status interface to the MIPS I/O read path, so software never drives the receiver's clear line directly.
- Tracks FIFO overrun.

---
 rtl/uart_rx_ctrl.sv | 73 +++++++
 tb/tb_uart_rx_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver sequencer with FWFT byte FIFO, one-cycle flag-clear pulse and sticky overrun.
// Optional UART_RX_OVR_CNT_EN adds an 8-bit saturating dropped-frame counter ovr_count.
module uart_rx_ctrl #(
  parameter int Nbit       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Nbit-1:0]    rx_data,
  input  logic               rx_flag,
  output logic               rx_clr,
  input  logic               rd_en,
  output logic [Nbit-1:0]    rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               overrun,
  input  logic               ovr_clr
`ifdef UART_RX_OVR_CNT_EN
  ,
  output logic [7:0]         ovr_count
`endif
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CAPTURE  = 2'd1;
  localparam logic [1:0] CLEAR    = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;
  logic [1:0]         state, state_nx;
  logic [Nbit-1:0]    mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic               push, pop, drop;
  assign pop     = rd_en && !empty;
  // A pop in the capture cycle frees a slot, so a full FIFO can still accept the frame.
  assign push    = (state == CAPTURE) && (!full || pop);
  assign drop    = (state == CAPTURE) && !push;
  assign empty   = (level == '0);
  assign full    = (level == (FIFO_AW+1)'(FIFO_DEPTH));
  assign rd_data = empty ? '0 : mem[rptr];
  always_comb begin
    state_nx = (state == IDLE)    ? (rx_flag ? CAPTURE : IDLE) :
               (state == CAPTURE) ? CLEAR :
               (state == CLEAR)   ? WAIT_LOW :
               (rx_flag ? CLEAR : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rx_clr  <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      rx_clr  <= (state_nx == CLEAR);
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop) level <= level + (FIFO_AW+1)'(1);
      else if (pop && !push) level <= level - (FIFO_AW+1)'(1);
      overrun <= drop || (overrun && !ovr_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rx_data;
  end
`ifdef UART_RX_OVR_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset || ovr_clr) ovr_count <= 8'd0;
    else if (drop && ovr_count != 8'hFF) ovr_count <= ovr_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed vector table plus hand-written multi-cycle sequences for uart_rx_ctrl.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_flag = 1'b0;
  logic       rx_clr;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full;
  logic [2:0] level;
  logic       overrun;
  logic       ovr_clr = 1'b0;
`ifdef UART_RX_OVR_CNT_EN
  logic [7:0] ovr_count;
`endif
  int tests = 0;
  int failed = 0;

  uart_rx_ctrl dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_flag(rx_flag), .rx_clr(rx_clr),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .level(level),
    .overrun(overrun), .ovr_clr(ovr_clr)
`ifdef UART_RX_OVR_CNT_EN
    , .ovr_count(ovr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, flag, rd, oc;
    logic [7:0] data;
    logic       e_clr;
    logic [7:0] e_rd;
    logic       e_empty, e_full;
    logic [2:0] e_lvl;
    logic       e_ovr;
  } vec_t;

  vec_t v[7];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic oc);
    rx_flag = 1'b1;
    rx_data = d;
    @(posedge clk); #1;
    rd_en = p;
    ovr_clr = oc;
    chk("clr_in_capture", rx_clr, 0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    ovr_clr = 1'b0;
    rx_flag = 1'b0;
    chk("clr_pulse", rx_clr, 1);
    @(posedge clk); #1;
    chk("clr_single", rx_clr, 0);
    @(posedge clk); #1;
  endtask

  task automatic pop_chk(input logic [7:0] e);
    chk("pop_head", rd_data, e);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    int exp_clr[7];
    int pulses;
    logic prev;
    // rst_n flag rd oc data | clr rd_data empty full lvl ovr
    v[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
    v[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
    v[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd1, 1'b0};
    v[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 1'b0};
    v[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0, 3'd1, 1'b0};
    v[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
    v[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0};
    exp_clr = '{0, 1, 0, 1, 0, 1, 0};
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      reset = v[i].rst_n;
      rx_flag = v[i].flag;
      rx_data = v[i].data;
      rd_en = v[i].rd;
      ovr_clr = v[i].oc;
      @(posedge clk); #1;
      chk($sformatf("v%0d_rx_clr", i), rx_clr, v[i].e_clr);
      chk($sformatf("v%0d_rd_data", i), rd_data, v[i].e_rd);
      chk($sformatf("v%0d_empty", i), empty, v[i].e_empty);
      chk($sformatf("v%0d_full", i), full, v[i].e_full);
      chk($sformatf("v%0d_level", i), level, v[i].e_lvl);
      chk($sformatf("v%0d_overrun", i), overrun, v[i].e_ovr);
    end
    rd_en = 1'b0;
    // Fill to full, then two dropped frames (second with simultaneous ovr_clr)
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_level", level, 4);
    chk("fill_ovr0", overrun, 0);
    send_frame(8'h05, 1'b0, 1'b0);
    chk("drop_ovr", overrun, 1);
    chk("drop_level", level, 4);
`ifdef UART_RX_OVR_CNT_EN
    chk("drop_cnt", ovr_count, 1);
`endif
    send_frame(8'h06, 1'b0, 1'b1);
    chk("set_wins_ovr", overrun, 1);
`ifdef UART_RX_OVR_CNT_EN
    chk("clr_wins_cnt", ovr_count, 0);
`endif
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    for (int i = 1; i <= 4; i++) pop_chk(8'(i));
    chk("drain_empty", empty, 1);
    chk("drain_rd_zero", rd_data, 0);
    // Push while full with simultaneous pop
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
    chk("pp_head_before", rd_data, 8'h01);
    send_frame(8'h05, 1'b1, 1'b0);
    chk("pp_level", level, 4);
    chk("pp_ovr", overrun, 0);
    for (int i = 2; i <= 5; i++) pop_chk(8'(i));
    chk("pp_empty", empty, 1);
    // Stuck flag: one write, clear pulses separated by a low cycle
    rx_flag = 1'b1;
    rx_data = 8'h77;
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stuck_clr%0d", i), rx_clr, exp_clr[i]);
      if (prev && rx_clr) chk("stuck_back_to_back", 1, 0);
      prev = rx_clr;
      if (rx_clr) pulses++;
    end
    rx_flag = 1'b0;
    @(posedge clk); #1;
    chk("stuck_pulses", pulses, 3);
    chk("stuck_level", level, 1);
    chk("stuck_clr_end", rx_clr, 0);
    pop_chk(8'h77);
    send_frame(8'h88, 1'b0, 1'b0);
    chk("stuck_idle_level", level, 1);
    pop_chk(8'h88);
    // Pointer wrap
    for (int i = 0; i < 10; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
      chk($sformatf("wrap_level%0d", i), level, 1);
      pop_chk(8'h10 + 8'(i));
    end
    chk("wrap_empty", empty, 1);
    // Mid-operation reset during CLEAR, asserted between edges
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
    send_frame(8'h09, 1'b0, 1'b0);
    rx_flag = 1'b1;
    rx_data = 8'h0A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mr_in_clear", rx_clr, 1);
    rx_flag = 1'b0;
    reset = 1'b0;
    #3;
    chk("mr_async_clr", rx_clr, 1);
    chk("mr_async_ovr", overrun, 1);
    chk("mr_async_full", full, 1);
    @(posedge clk); #1;
    chk("mr_clr", rx_clr, 0);
    chk("mr_empty", empty, 1);
    chk("mr_ovr", overrun, 0);
    chk("mr_level", level, 0);
`ifdef UART_RX_OVR_CNT_EN
    chk("mr_cnt", ovr_count, 0);
`endif
    reset = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    pop_chk(8'h5A);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
